// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial 2-bit adder and the blocks that feed it.
package adder_pkg;

  localparam int ADDER_OPW    = 2;
  localparam int ADDER_PERIOD = 4;
  localparam int ADDER_RES_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSB  = 2'd1,
    LSB  = 2'd2,
    WAIT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/operand_fifo.sv
// Small synchronous FIFO holding operand pairs until the serializer sends them.
module operand_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; validity is tracked by count, and resettable RAM costs flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_operand_serializer.sv
// Buffers parallel operand pairs and replays them MSB-first on the adder's
// en_i/ina/inb serial protocol, one transaction every GAP cycles.
module adder_operand_serializer
  import adder_pkg::*;
#(
  parameter int OPW   = ADDER_OPW,
  parameter int DEPTH = 2,
  parameter int GAP   = ADDER_PERIOD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPW-1:0]             in_a,
  input  logic [OPW-1:0]             in_b,
  output logic                       en_i,
  output logic                       ina,
  output logic                       inb,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  if (OPW != ADDER_OPW) begin : g_bad_opw
    $error("adder_operand_serializer: OPW must equal the adder operand width");
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("adder_operand_serializer: DEPTH must be in 1..8");
  end
  if (GAP < ADDER_PERIOD) begin : g_bad_gap
    $error("adder_operand_serializer: GAP must be at least the adder period");
  end

  localparam int PW  = 2 * OPW;
  localparam int WCW = $clog2(GAP);

  seq_state_t     state, state_next;
  logic [WCW-1:0] wcnt, wcnt_next;
  logic [PW-1:0]  pair_q, pair_next;  // {A, B} of the pair on the wire
  logic [PW-1:0]  fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           en_next, ina_next, inb_next;

  operand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    pair_next  = pair_q;
    pop        = 1'b0;
    en_next    = 1'b0;
    ina_next   = 1'b0;
    inb_next   = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      MSB: begin
        state_next = LSB;
        ina_next   = pair_q[OPW];
        inb_next   = pair_q[0];
      end
      LSB: begin
        state_next = WAIT;
        wcnt_next  = WCW'(GAP - 3);
      end
      WAIT: begin
        if (wcnt != '0)       wcnt_next  = wcnt - 1'b1;
        else if (!fifo_empty) pop        = 1'b1;
        else                  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Popping always launches a transaction: latch the pair and present its MSBs.
    if (pop) begin
      state_next = MSB;
      pair_next  = fifo_rdata;
      en_next    = 1'b1;
      ina_next   = fifo_rdata[PW-1];
      inb_next   = fifo_rdata[OPW-1];
    end
  end

  // Reset parks in WAIT so an adder transaction already in flight can drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT;
      wcnt   <= WCW'(GAP - 1);
      pair_q <= '0;
      en_i   <= 1'b0;
      ina    <= 1'b0;
      inb    <= 1'b0;
    end else begin
      state  <= state_next;
      wcnt   <= wcnt_next;
      pair_q <= pair_next;
      en_i   <= en_next;
      ina    <= ina_next;
      inb    <= inb_next;
    end
  end

endmodule

// File: tb/tb_adder_operand_serializer.sv
// Directed self-checking bench for adder_operand_serializer at default parameters.
module tb_adder_operand_serializer;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_a = '0;
  logic [1:0] in_b = '0;
  logic       in_ready, en_i, ina, inb, busy;
  logic [1:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_operand_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .en_i     (en_i),
    .ina      (ina),
    .inb      (inb),
    .busy     (busy),
    .count    (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back stream: {en_i, ina, inb} and count expected in cycles 0..18.
  logic [2:0] t2_out [19] = '{3'b000, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 3'b101,
                              3'b011, 3'b000, 3'b000, 3'b110, 3'b010, 3'b000, 3'b000,
                              3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [1:0] t2_cnt [19] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2,
                              2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

  initial begin
    logic       a1, b1, a0, b0, pending;
    logic [3:0] pv, gv;
    logic [2:0] exp_sum, got_sum;
    int         pi, got, cyc, last_pulse, n;

    // Reset state.
    step();
    step();
    check("rst_en_i", en_i, 0);
    check("rst_serial", {ina, inb}, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 1);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_quiet", en_i, 0);
      check("post_rst_busy", busy, 1);
      step();
    end
    check("post_rst_idle", busy, 0);

    // Single pair A=3, B=1 from IDLE.
    in_valid = 1'b1; in_a = 2'd3; in_b = 2'd1;
    step();
    in_valid = 1'b0;
    check("t1_count", count, 1);
    check("t1_early_en", en_i, 0);
    step();
    check("t1_msb", {en_i, ina, inb}, 3'b110);
    a1 = ina; b1 = inb;
    step();
    check("t1_lsb", {en_i, ina, inb}, 3'b011);
    got_sum = 3'({1'b0, a1, ina} + {1'b0, b1, inb});
    check("t1_sum", got_sum, 4);
    step(); step(); step();
    check("t1_idle", busy, 0);

    // Stream of four pairs: push/pop overlap, full FIFO stall, order preserved.
    for (int c = 0; c < 19; c++) begin
      check("t2_serial", {en_i, ina, inb}, t2_out[c]);
      check("t2_count", count, t2_cnt[c]);
      check("t2_in_ready", in_ready, (t2_cnt[c] < 2) ? 1 : 0);
      case (c)
        0:               begin in_valid = 1'b1; in_a = 2'd2; in_b = 2'd1; end
        1:               begin in_valid = 1'b1; in_a = 2'd1; in_b = 2'd3; end
        2:               begin in_valid = 1'b1; in_a = 2'd3; in_b = 2'd0; end
        3, 4, 5, 6:      begin in_valid = 1'b1; in_a = 2'd0; in_b = 2'd2; end
        default:         in_valid = 1'b0;
      endcase
      step();
    end
    check("t2_idle", busy, 0);

    // Reset asserted during the LSB cycle with one more pair still queued.
    in_valid = 1'b1; in_a = 2'd3; in_b = 2'd3;
    step();
    in_a = 2'd1; in_b = 2'd2;
    step();
    in_valid = 1'b0;
    check("t4_msb", {en_i, ina, inb}, 3'b111);
    step();
    check("t4_lsb", {en_i, ina, inb}, 3'b011);
    check("t4_count_pre", count, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t4_async_out", {en_i, ina, inb}, 0);
    check("t4_flush", count, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_quiet", en_i, 0);
      step();
    end
    n = 0;
    while (busy && n < 10) begin
      check("t4_quiet_tail", en_i, 0);
      step();
      n++;
    end
    check("t4_back_idle", busy, 0);
    check("t4_wait_len", n, 1);
    check("t4_nothing_sent", count, 0);

    // Sweep all 16 pairs back-to-back, deserializing and adding like the adder.
    pi = 0; got = 0; cyc = 0; last_pulse = -1; pending = 1'b0;
    while (got < 16 && cyc < 200) begin
      if (pending) begin
        a0 = ina; b0 = inb;
        gv = 4'(got);
        check("t5_pair", {a1, a0, b1, b0}, gv);
        exp_sum = 3'(gv[3:2]) + 3'(gv[1:0]);
        got_sum = 3'({1'b0, a1, a0} + {1'b0, b1, b0});
        check("t5_sum", got_sum, exp_sum);
        got++;
        pending = 1'b0;
      end
      if (en_i) begin
        a1 = ina; b1 = inb; pending = 1'b1;
        if (last_pulse >= 0) check("t5_spacing", cyc - last_pulse, GAP);
        last_pulse = cyc;
      end
      if (pi < 16 && in_ready) begin
        pv = 4'(pi);
        in_valid = 1'b1; in_a = pv[3:2]; in_b = pv[1:0];
        pi++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("t5_done", got, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
